// File: rtl/sequence_pkg.sv
// Shared constants for the 8-byte sequence link: the pattern itself and the
// checker's lock FSM encoding.
package sequence_pkg;

    localparam int SEQ_LEN = 8;

    // Entry 0 is the first byte on the wire (AF).
    localparam logic [SEQ_LEN-1:0][7:0] SEQ_PATTERN = {
        8'h8D, 8'h0B, 8'hE2, 8'hFF, 8'h78, 8'hE2, 8'hBC, 8'hAF
    };

    // The only self-overlap in the pattern is its leading byte.
    localparam logic [7:0] SEQ_HEAD = 8'hAF;

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    typedef enum logic [0:0] {
        SEARCH = ST_SEARCH,
        LOCKED = ST_LOCKED
    } seq_state_e;

endpackage

// File: rtl/sequence_checker_if.sv
// Byte-stream sink and status bundle of the sequence checker.
interface sequence_checker_if #(
    parameter int COUNT_W = 16
);
    logic               enable;
    logic [7:0]         data;
    logic               clear_counts;
    logic               locked;
    logic               match;
    logic               error;
    logic [COUNT_W-1:0] match_count;
    logic [COUNT_W-1:0] error_count;

    modport master (
        output enable, data, clear_counts,
        input  locked, match, error, match_count, error_count
    );

    modport slave (
        input  enable, data, clear_counts,
        output locked, match, error, match_count, error_count
    );
endinterface

// File: rtl/seq_sat_counter.sv
// Saturating event counter with a synchronous clear that beats a coincident
// increment.
module seq_sat_counter #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc_i,
    input  logic               clr_i,
    output logic [COUNT_W-1:0] count_o
);
    logic [COUNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {COUNT_W{1'b1}})) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/sequence_checker.sv
// Receive-side self-check for the 8-byte sequence generator: hunts for the
// pattern, locks on it, then flags every byte that deviates.
module sequence_checker
    import sequence_pkg::*;
#(
    parameter int LOSS_THRESHOLD = 4,
    parameter int COUNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    sequence_checker_if.slave bus
);
    localparam int                MISS_W     = $clog2(LOSS_THRESHOLD + 1);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(LOSS_THRESHOLD);
    localparam logic [2:0]        IDX_LAST   = 3'(SEQ_LEN - 1);

    seq_state_e        state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [MISS_W-1:0] miss_q, miss_d;
    logic              clean_q, clean_d;
    logic              match_q, match_d;
    logic              error_q, error_d;

    logic              hit;
    logic [2:0]        restart_idx;
    logic [MISS_W-1:0] miss_next;

    assign hit         = (bus.data == SEQ_PATTERN[idx_q]);
    assign restart_idx = (bus.data == SEQ_HEAD) ? 3'd1 : 3'd0;
    assign miss_next   = miss_q + MISS_W'(1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        miss_d  = miss_q;
        clean_d = clean_q;
        match_d = 1'b0;
        error_d = 1'b0;

        if (bus.enable) begin
            if (state_q == SEARCH) begin
                if (hit && (idx_q == IDX_LAST)) begin
                    match_d = 1'b1;
                    state_d = LOCKED;
                    idx_d   = 3'd0;
                    clean_d = 1'b1;
                    miss_d  = '0;
                end else if (hit) begin
                    idx_d = idx_q + 3'd1;
                end else begin
                    idx_d = restart_idx;
                end
            end else begin
                idx_d = idx_q + 3'd1;
                if (hit) begin
                    miss_d = '0;
                end else begin
                    error_d = 1'b1;
                    clean_d = 1'b0;
                    miss_d  = miss_next;
                end

                // Sequence boundary: report a clean sequence, start the next one fresh.
                if (idx_q == IDX_LAST) begin
                    match_d = clean_q && hit;
                    clean_d = 1'b1;
                end

                if (!hit && (miss_next == MISS_LIMIT)) begin
                    state_d = SEARCH;
                    idx_d   = restart_idx;
                    miss_d  = '0;
                    clean_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= SEARCH;
            idx_q   <= 3'd0;
            miss_q  <= '0;
            clean_q <= 1'b1;
            match_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            miss_q  <= miss_d;
            clean_q <= clean_d;
            match_q <= match_d;
            error_q <= error_d;
        end
    end

    assign bus.locked = (state_q == LOCKED);
    assign bus.match  = match_q;
    assign bus.error  = error_q;

    // Counters see the same next-state pulses, so they move on the same edge.
    seq_sat_counter #(.COUNT_W(COUNT_W)) u_match_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (match_d),
        .clr_i   (bus.clear_counts),
        .count_o (bus.match_count)
    );

    seq_sat_counter #(.COUNT_W(COUNT_W)) u_error_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc_i   (error_d),
        .clr_i   (bus.clear_counts),
        .count_o (bus.error_count)
    );
endmodule

// File: tb/tb_sequence_checker.sv
// Scoreboard bench: two checkers (16-bit and 2-bit counters) fed the same
// stream, compared against a sliding-window reference model.
module tb_sequence_checker;
    localparam int LOSS = 4;
    localparam logic [7:0] PAT [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

    typedef struct {
        bit locked;
        bit match;
        bit error;
        int mc16;
        int ec16;
        int mc2;
        int ec2;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sequence_checker_if #(.COUNT_W(16)) b16 ();
    sequence_checker_if #(.COUNT_W(2))  b2  ();

    sequence_checker #(.LOSS_THRESHOLD(LOSS), .COUNT_W(16)) dut16 (
        .clk(clk), .reset(reset), .bus(b16)
    );
    sequence_checker #(.LOSS_THRESHOLD(LOSS), .COUNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .bus(b2)
    );

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    // Reference model state
    bit         m_locked = 0;
    logic [7:0] hist[$];
    int         n_lock, misses, seq_errs;
    int         mc16, ec16, mc2, ec2;

    function automatic int sat(input int v, input int lim);
        return (v > lim) ? lim : v;
    endfunction

    function automatic bit window_hit();
        if (hist.size() != 8) return 1'b0;
        for (int i = 0; i < 8; i++) if (hist[i] != PAT[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input bit rst_n, input bit en, input logic [7:0] d,
                              input bit clr, output exp_t e);
        bit m, er, good;
        int pos;
        m  = 1'b0;
        er = 1'b0;
        if (!rst_n) begin
            m_locked = 1'b0;
            hist.delete();
            n_lock = 0; misses = 0; seq_errs = 0;
            mc16 = 0; ec16 = 0; mc2 = 0; ec2 = 0;
        end else begin
            if (en && !m_locked) begin
                hist.push_back(d);
                if (hist.size() > 8) void'(hist.pop_front());
                if (window_hit()) begin
                    m = 1'b1;
                    m_locked = 1'b1;
                    n_lock = 0; misses = 0; seq_errs = 0;
                    hist.delete();
                end
            end else if (en) begin
                pos  = n_lock % 8;
                good = (d == PAT[pos]);
                if (good) misses = 0;
                else begin
                    er = 1'b1;
                    seq_errs++;
                    misses++;
                end
                if (pos == 7) begin
                    m = good && (seq_errs == 0);
                    seq_errs = 0;
                end
                n_lock++;
                if (misses == LOSS) begin
                    m_locked = 1'b0;
                    misses = 0;
                    hist.delete();
                    hist.push_back(d);
                end
            end
            mc16 = clr ? 0 : sat(mc16 + int'(m), 65535);
            ec16 = clr ? 0 : sat(ec16 + int'(er), 65535);
            mc2  = clr ? 0 : sat(mc2 + int'(m), 3);
            ec2  = clr ? 0 : sat(ec2 + int'(er), 3);
        end
        e.locked = m_locked;
        e.match  = m;
        e.error  = er;
        e.mc16   = mc16;
        e.ec16   = ec16;
        e.mc2    = mc2;
        e.ec2    = ec2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, expv);
        end
    endtask

    // Monitor: outputs are valid every cycle, one expectation per accepted edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("locked16", b16.locked, e.locked);
                chk("match16",  b16.match,  e.match);
                chk("error16",  b16.error,  e.error);
                chk("mcount16", b16.match_count, e.mc16);
                chk("ecount16", b16.error_count, e.ec16);
                chk("locked2",  b2.locked,  e.locked);
                chk("match2",   b2.match,   e.match);
                chk("error2",   b2.error,   e.error);
                chk("mcount2",  b2.match_count, e.mc2);
                chk("ecount2",  b2.error_count, e.ec2);
            end
        end
    end

    task automatic step(input bit rst_n, input bit en, input logic [7:0] d, input bit clr);
        exp_t e;
        reset           = rst_n;
        b16.enable      = en;
        b16.data        = d;
        b16.clear_counts = clr;
        b2.enable       = en;
        b2.data         = d;
        b2.clear_counts = clr;
        model_step(rst_n, en, d, clr, e);
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d, input bit gappy);
        if (gappy) repeat ($urandom_range(0, 2)) step(1'b1, 1'b0, 8'($urandom), 1'b0);
        step(1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic send_pat(input bit gappy, input int bad_pos, input logic [7:0] bad_val);
        for (int i = 0; i < 8; i++) send((i == bad_pos) ? bad_val : PAT[i], gappy);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int gp;
        int bad_pct;
        logic [7:0] d;
        bit en;

        step(1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'hAF, 1'b0);

        // Leading stray AF, then first lock
        send(8'hAF, 1'b0);
        send_pat(1'b0, -1, 8'h00);
        repeat (2) send_pat(1'b0, -1, 8'h00);

        // Single corrupted byte, then a clean sequence
        send_pat(1'b0, 4, 8'h00);
        send_pat(1'b0, -1, 8'h00);

        // Loss of lock after LOSS consecutive misses, then relock
        repeat (LOSS) send(8'h00, 1'b0);
        send_pat(1'b0, -1, 8'h00);

        // Enable gaps inside sequences
        repeat (3) send_pat(1'b1, -1, 8'h00);

        // Reset mid-sequence: trailing half must not lock
        for (int i = 0; i < 4; i++) send(PAT[i], 1'b0);
        step(1'b0, 1'b1, 8'hE2, 1'b0);
        for (int i = 4; i < 8; i++) send(PAT[i], 1'b0);
        send_pat(1'b1, -1, 8'h00);

        // Saturation of the narrow counters, then clear coincident with a match
        step(1'b1, 1'b0, 8'h00, 1'b1);
        repeat (5) send_pat(1'b0, -1, 8'h00);
        for (int i = 0; i < 7; i++) send(PAT[i], 1'b0);
        step(1'b1, 1'b1, PAT[7], 1'b1);
        send_pat(1'b0, -1, 8'h00);

        // Randomized stream with alternating noise levels
        gp = 0;
        for (int i = 0; i < 1200; i++) begin
            bad_pct = ((i / 100) % 2 == 1) ? 60 : 8;
            en = ($urandom_range(0, 3) != 0);
            d  = ($urandom_range(0, 99) < bad_pct) ? 8'($urandom) : PAT[gp];
            if (en) gp = (gp + 1) % 8;
            step(($urandom_range(0, 399) != 0), en, d, ($urandom_range(0, 79) == 0));
        end

        step(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
